// File: rtl/prf_pkg.sv
// rtl/prf_pkg.sv - shared PRF geometry and CDB requester indices
package prf_pkg;

  localparam int PRF_DEPTH      = 48;
  localparam int PRF_ADDR_WIDTH = 6;
  localparam int PRF_WIDTH      = 32;
  localparam int N_REQ          = 4;

  typedef enum logic [1:0] {
    REQ_INT  = 2'd0,
    REQ_MULT = 2'd1,
    REQ_DIV  = 2'd2,
    REQ_LSQ  = 2'd3
  } req_id_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant, search starts at rr_ptr
module rr_arbiter #(
  parameter int N_REQ = prf_pkg::N_REQ,
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] gnt
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PTR_W'((int'(rr_ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter driving a registered PRF write port
module cdb_arbiter #(
  parameter int N_REQ          = prf_pkg::N_REQ,
  parameter int PRF_ADDR_WIDTH = prf_pkg::PRF_ADDR_WIDTH,
  parameter int PRF_WIDTH      = prf_pkg::PRF_WIDTH,
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req,
  input  logic [N_REQ*PRF_ADDR_WIDTH-1:0] req_tag,
  input  logic [N_REQ*PRF_WIDTH-1:0]      req_data,
  input  logic                            flush,
  output logic [N_REQ-1:0]                gnt,
  output logic                            cdb_w_en,
  output logic [PRF_ADDR_WIDTH-1:0]       cdb_w_addr,
  output logic [PRF_WIDTH-1:0]            cdb_din,
  output logic [15:0]                     bcast_cnt
);

  logic [PTR_W-1:0]          rr_ptr;
  logic [PTR_W-1:0]          next_ptr;
  logic [N_REQ-1:0]          arb_gnt;
  logic [PRF_ADDR_WIDTH-1:0] sel_tag;
  logic [PRF_WIDTH-1:0]      sel_data;
  logic                      any_gnt;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (arb_gnt)
  );

  // Reset is folded in combinationally so gnt drops without waiting for an edge.
  assign gnt     = (reset && !flush) ? arb_gnt : '0;
  assign any_gnt = |gnt;

  // Requester 0 occupies the MSB slice of the packed tag/data buses.
  always_comb begin
    sel_tag  = '0;
    sel_data = '0;
    next_ptr = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        sel_tag  = req_tag[(N_REQ-1-k)*PRF_ADDR_WIDTH +: PRF_ADDR_WIDTH];
        sel_data = req_data[(N_REQ-1-k)*PRF_WIDTH +: PRF_WIDTH];
        next_ptr = PTR_W'((k + 1) % N_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdb_w_en   <= 1'b0;
      cdb_w_addr <= '0;
      cdb_din    <= '0;
      rr_ptr     <= '0;
      bcast_cnt  <= '0;
    end else begin
      cdb_w_en <= any_gnt;
      if (any_gnt) begin
        cdb_w_addr <= sel_tag;
        cdb_din    <= sel_data;
        rr_ptr     <= next_ptr;
        if (bcast_cnt != 16'hFFFF) begin
          bcast_cnt <= bcast_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
  import prf_pkg::*;

  typedef struct packed {
    logic [PRF_ADDR_WIDTH-1:0] tag;
    logic [PRF_WIDTH-1:0]      data;
  } sb_t;

  logic                            clk;
  logic                            reset;
  logic [N_REQ-1:0]                req;
  logic [N_REQ*PRF_ADDR_WIDTH-1:0] req_tag;
  logic [N_REQ*PRF_WIDTH-1:0]      req_data;
  logic                            flush;
  logic [N_REQ-1:0]                gnt;
  logic                            cdb_w_en;
  logic [PRF_ADDR_WIDTH-1:0]       cdb_w_addr;
  logic [PRF_WIDTH-1:0]            cdb_din;
  logic [15:0]                     bcast_cnt;

  logic [PRF_ADDR_WIDTH-1:0] tag_a  [N_REQ];
  logic [PRF_WIDTH-1:0]      data_a [N_REQ];
  logic [PRF_WIDTH-1:0]      prf_model [64];
  sb_t                       sb [$];
  int                        total = 0;
  int                        bad   = 0;

  cdb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_tag    (req_tag),
    .req_data   (req_data),
    .flush      (flush),
    .gnt        (gnt),
    .cdb_w_en   (cdb_w_en),
    .cdb_w_addr (cdb_w_addr),
    .cdb_din    (cdb_din),
    .bcast_cnt  (bcast_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic drive(input logic [N_REQ-1:0] r, input logic f);
    req   = r;
    flush = f;
    for (int k = 0; k < N_REQ; k++) begin
      req_tag[(N_REQ-1-k)*PRF_ADDR_WIDTH +: PRF_ADDR_WIDTH] = tag_a[k];
      req_data[(N_REQ-1-k)*PRF_WIDTH +: PRF_WIDTH]          = data_a[k];
    end
  endtask

  task automatic observe(input logic exp_en);
    sb_t e;
    chk("cdb_w_en", 32'(cdb_w_en), 32'(exp_en));
    if (cdb_w_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_depth_at_bcast", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("cdb_w_addr", 32'(cdb_w_addr), 32'(e.tag));
        chk("cdb_din", cdb_din, e.data);
        prf_model[cdb_w_addr] = cdb_din;
      end
    end
  endtask

  // One cycle: check last cycle's broadcast and this cycle's grant at the falling edge.
  task automatic step(input logic [N_REQ-1:0] exp_gnt, input logic exp_en);
    @(negedge clk);
    observe(exp_en);
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    for (int k = 0; k < N_REQ; k++) begin
      if (exp_gnt[k]) sb.push_back({tag_a[k], data_a[k]});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < N_REQ; k++) begin
      tag_a[k]  = '0;
      data_a[k] = '0;
    end
    for (int a = 0; a < 64; a++) prf_model[a] = '0;
    reset = 1'b1;
    drive(4'b1111, 1'b0);
    #1 reset = 1'b0;
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_en", 32'(cdb_w_en), 32'd0);
    chk("rst_addr", 32'(cdb_w_addr), 32'd0);
    chk("rst_din", cdb_din, 32'd0);
    chk("rst_cnt", 32'(bcast_cnt), 32'd0);
    drive(4'b0000, 1'b0);
    #9 reset = 1'b1;
    @(posedge clk);
    #1;

    // single div request
    tag_a[REQ_DIV] = 6'd5; data_a[REQ_DIV] = 32'd1005;
    drive(4'b0100, 1'b0); step(4'b0100, 1'b0);
    drive(4'b0000, 1'b0); step(4'b0000, 1'b1);
    chk("cnt_after_first", 32'(bcast_cnt), 32'd1);
    step(4'b0000, 1'b0);
    chk("hold_addr", 32'(cdb_w_addr), 32'd5);
    chk("hold_din", cdb_din, 32'd1005);

    // lsq alone moves rr_ptr back to int
    tag_a[REQ_LSQ] = 6'd20; data_a[REQ_LSQ] = 32'd3000;
    drive(4'b1000, 1'b0); step(4'b1000, 1'b0);

    for (int k = 0; k < N_REQ; k++) begin
      tag_a[k]  = PRF_ADDR_WIDTH'(10 + k);
      data_a[k] = PRF_WIDTH'(2000 + k);
    end
    drive(4'b1111, 1'b0);
    step(4'b0001, 1'b1);
    step(4'b0010, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b1000, 1'b1);
    step(4'b0001, 1'b1);
    drive(4'b0000, 1'b0); step(4'b0000, 1'b1);

    // flush blocks one cycle, registered broadcast survives a flush
    tag_a[REQ_MULT] = 6'd47; data_a[REQ_MULT] = 32'd22222;
    tag_a[REQ_LSQ]  = 6'd30; data_a[REQ_LSQ]  = 32'd33333;
    drive(4'b1010, 1'b1); step(4'b0000, 1'b0);
    drive(4'b1010, 1'b0); step(4'b0010, 1'b0);
    drive(4'b1000, 1'b0); step(4'b1000, 1'b1);
    drive(4'b0000, 1'b1); step(4'b0000, 1'b1);
    drive(4'b0000, 1'b0); step(4'b0000, 1'b0);

    tag_a[REQ_DIV] = 6'd7;
    for (int i = 0; i < 3; i++) begin
      data_a[REQ_DIV] = PRF_WIDTH'(4000 + i);
      drive(4'b0100, 1'b0);
      step(4'b0100, (i != 0));
    end
    drive(4'b0000, 1'b0);
    @(negedge clk);
    observe(1'b1);

    // asynchronous reset while a broadcast is on the bus
    for (int k = 0; k < N_REQ; k++) begin
      tag_a[k]  = PRF_ADDR_WIDTH'(40 + k);
      data_a[k] = PRF_WIDTH'(5000 + k);
    end
    #2;
    drive(4'b1111, 1'b0);
    reset = 1'b0;
    #1;
    chk("async_rst_en", 32'(cdb_w_en), 32'd0);
    chk("async_rst_gnt", 32'(gnt), 32'd0);
    chk("async_rst_cnt", 32'(bcast_cnt), 32'd0);
    chk("async_rst_addr", 32'(cdb_w_addr), 32'd0);
    drive(4'b0000, 1'b0);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    drive(4'b1111, 1'b0); step(4'b0001, 1'b0);
    drive(4'b0000, 1'b0); step(4'b0000, 1'b1);
    chk("cnt_after_reset", 32'(bcast_cnt), 32'd1);

    // counter saturation
    tag_a[REQ_INT] = 6'd1; data_a[REQ_INT] = 32'd1;
    drive(4'b0001, 1'b0);
    repeat (65533) @(posedge clk);
    #1;
    chk("cnt_fffe", 32'(bcast_cnt), 32'h0000FFFE);
    @(posedge clk);
    #1;
    chk("cnt_ffff", 32'(bcast_cnt), 32'h0000FFFF);
    repeat (6) @(posedge clk);
    #1;
    chk("cnt_ffff_held", 32'(bcast_cnt), 32'h0000FFFF);
    drive(4'b0000, 1'b0);
    @(posedge clk);
    #1;

    chk("prf_5", prf_model[5], 32'd1005);
    chk("prf_20", prf_model[20], 32'd3000);
    chk("prf_10", prf_model[10], 32'd2000);
    chk("prf_13", prf_model[13], 32'd2003);
    chk("prf_47", prf_model[47], 32'd22222);
    chk("prf_30", prf_model[30], 32'd33333);
    chk("prf_7", prf_model[7], 32'd4002);
    chk("prf_40", prf_model[40], 32'd5000);
    chk("sb_leftover", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of CDB requesters; index 0=int, 1=mult, 2=div, 3=lsq.
REQ-002 Parameter PRF_ADDR_WIDTH, default 6: physical register tag width, for 48 PRF entries.
REQ-003 Parameter PRF_WIDTH, default 32: result data width.
REQ-004 clk  input  1  single clock for the block; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-006 req  input  N_REQ  per-requester broadcast request.
REQ-007 req_tag  input  N_REQ*PRF_ADDR_WIDTH  destination PRF tag per requester, requester 0 in the MSBs.
REQ-008 req_data  input  N_REQ*PRF_WIDTH  result data per requester, requester 0 in the MSBs.
REQ-009 gnt  output  N_REQ  one-hot combinational grant in the current cycle.
REQ-010 flush  input  1  mispredict flush; suppresses grants in the current cycle.
REQ-011 cdb_w_en  output  1  registered PRF write enable (the CDB valid).
REQ-012 cdb_w_addr  output  PRF_ADDR_WIDTH  registered PRF write tag.
REQ-013 cdb_din  output  PRF_WIDTH  registered PRF write data.
REQ-014 bcast_cnt  output  16  count of broadcasts; saturates at 16'hFFFF.

Function
REQ-015 gnt SHALL be at most one-hot; it SHALL be 0 when req==0 or flush==1.
REQ-016 Arbitration SHALL be round-robin; rr_ptr (log2 N_REQ bits) names the highest-priority requester; search order is rr_ptr, rr_ptr+1, ... mod N_REQ.
REQ-017 On a grant to requester k, rr_ptr SHALL become (k+1) mod N_REQ at the next edge; with no grant, rr_ptr SHALL hold.
REQ-018 Handshake: a requester SHALL hold req, tag and data stable until it sees gnt; it may drop req at the edge where gnt=1. An ungranted req SHALL be ignored, with no state change.
REQ-019 Latency: a grant in cycle t SHALL produce cdb_w_en=1 with the granted tag and data in cycle t+1, for exactly one cycle per grant.
REQ-020 With no grant in cycle t, cdb_w_en SHALL be 0 in cycle t+1; cdb_w_addr and cdb_din SHALL hold their previous values.
REQ-021 Back-to-back grants SHALL produce consecutive cdb_w_en=1 cycles; throughput is one broadcast per cycle.
REQ-022 Fairness: a requester holding req continuously SHALL be granted within N_REQ cycles.
REQ-023 A flush in cycle t SHALL block grants in cycle t only; a broadcast already registered from cycle t-1 SHALL still appear in cycle t.
REQ-024 bcast_cnt SHALL increment by 1 on every edge where any gnt bit is 1, and SHALL hold at 16'hFFFF once reached.
REQ-025 A single requester SHALL be granted every cycle regardless of rr_ptr.

Reset
REQ-026 While reset=0, the block SHALL asynchronously force cdb_w_en=0, cdb_w_addr=0, cdb_din=0, rr_ptr=0 and bcast_cnt=0.
REQ-027 gnt SHALL be 0 while reset=0.
REQ-028 Reset asserted mid-broadcast SHALL clear cdb_w_en immediately; it SHALL NOT wait for a clock edge.
REQ-029 After reset deassertion, the first arbitration SHALL start with requester 0 at highest priority.

Structure
REQ-030 PRF_ADDR_WIDTH, PRF_WIDTH, PRF_DEPTH=48, N_REQ and the requester index constants SHALL reside in shared package prf_pkg.
REQ-031 The combinational grant logic SHALL be a sub-module, rr_arbiter (inputs req and rr_ptr; output one-hot gnt).
REQ-032 cdb_w_* SHALL connect directly to the PRF cdb_w_en, cdb_w_addr and cdb_din ports, with no additional logic.

Verification
REQ-033 Reset release; req=4'b0100 with tag 5 and data 1005 -> gnt=4'b0100 that cycle; next cycle cdb_w_en=1, addr=5, din=1005; bcast_cnt=1.
REQ-034 All four requesters held continuously with tags 10..13 -> grant order int, mult, div, lsq, int; cdb_w_addr sequence 10, 11, 12, 13, 10; cdb_w_en high every cycle.
REQ-035 mult (tag 47, data 22222) and lsq both requesting, flush=1 for one cycle -> no grant that cycle; next cycle cdb_w_en=0; the following cycle mult is broadcast.
REQ-036 Reset pulled low while cdb_w_en=1 -> cdb_w_en=0 before the next edge; after release, int is granted ahead of the others.
REQ-037 Drive 65540 grants -> bcast_cnt=16'hFFFF, held there.
REQ-038 Scoreboard check: every granted (tag, data) pair appears exactly once on the CDB; a PRF read of that tag afterwards returns the broadcast data.
